instr_issue_seq: RTL and testbench

//  Producer side of the 4-bit opcode interface: fetches 16-bit instructions, drives opcode
//  (instr[15:12]) into the decoder, and holds it for the instruction's full execution time.

---
 rtl/instr_issue_if.sv | 23 ++
 rtl/instr_issue_seq.sv | 64 ++++++
 tb/tb_instr_issue_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instr_issue_if.sv
// instr_issue_if: fetch, memory-handshake and decoder-facing signals of the issue sequencer
interface instr_issue_if #(parameter int PC_W = 12);
  logic            run;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd_en;
  logic [15:0]     imem_data;
  logic            imem_valid;
  logic            dmem_req;
  logic            dmem_ready;
  logic [3:0]      opcode;
  logic [15:0]     instr;
  logic            commit;
  logic [PC_W-1:0] link_pc;
  logic            busy;
  modport master (
    input  run, imem_data, imem_valid, dmem_ready,
    output imem_addr, imem_rd_en, dmem_req, opcode, instr, commit, link_pc, busy
  );
  modport slave (
    output run, imem_data, imem_valid, dmem_ready,
    input  imem_addr, imem_rd_en, dmem_req, opcode, instr, commit, link_pc, busy
  );
endinterface

// File: rtl/instr_issue_seq.sv
// instr_issue_seq: fetches instructions and holds each opcode on the decoder for its full execution time
module instr_issue_seq #(
  parameter int PC_W       = 12,
  parameter int RESET_PC   = 0,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input logic             clk,
  input logic             rst,
  instr_issue_if.master   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, link_pc_q, link_pc_d, pc_inc;
  logic [15:0]     instr_q, instr_d, cnt_q, cnt_d;
  logic [3:0]      op, new_op;
  logic            exec, fetch_ok, is_mem, is_md, jmp, done;
  always_comb begin
    exec      = state_q == EXEC;
    op        = instr_q[15:12];
    new_op    = bus.imem_data[15:12];
    fetch_ok  = state_q == FETCH && bus.imem_valid;
    is_mem    = op == 4'b1100 || op == 4'b1101;
    is_md     = op == 4'b0011 || op == 4'b0110;
    jmp       = op == 4'b1010 || op == 4'b0111;
    pc_inc    = pc_q + PC_W'(1);
    // memory ops finish on the handshake, multi-cycle ops when the counter drains
    done      = exec && (is_mem ? bus.dmem_ready : is_md ? cnt_q == 16'd0 : 1'b1);
    state_d   = state_q == IDLE  ? (bus.run ? FETCH : IDLE) :
                state_q == FETCH ? (bus.imem_valid ? EXEC : FETCH) :
                state_q == EXEC  ? (done ? (bus.run ? FETCH : IDLE) : EXEC) : IDLE;
    instr_d   = fetch_ok ? bus.imem_data : instr_q;
    cnt_d     = fetch_ok ? (new_op == 4'b0011 ? 16'(MUL_CYCLES - 1) :
                            new_op == 4'b0110 ? 16'(DIV_CYCLES - 1) : 16'd0) :
                exec && cnt_q != 16'd0 ? cnt_q - 16'd1 : cnt_q;
    pc_d      = done ? (jmp ? instr_q[PC_W-1:0] : pc_inc) : pc_q;
    link_pc_d = done && op == 4'b0111 ? pc_inc : link_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= PC_W'(RESET_PC);
      instr_q   <= 16'd0;
      cnt_q     <= 16'd0;
      link_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      link_pc_q <= link_pc_d;
    end
  end
  assign bus.imem_addr  = pc_q;
  assign bus.imem_rd_en = state_q == FETCH;
  assign bus.dmem_req   = exec && is_mem;
  assign bus.opcode     = exec ? op : 4'b0000;
  assign bus.instr      = instr_q;
  assign bus.commit     = done;
  assign bus.link_pc    = link_pc_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_instr_issue_seq.sv
// tb_instr_issue_seq: directed checks of fetch, multi-cycle, jump, memory-handshake and reset sequencing
module tb_instr_issue_seq;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] mem [4096];
  int total = 0;
  int bad = 0;
  instr_issue_if #(.PC_W(12)) bus ();
  instr_issue_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_valid = bus.imem_rd_en;
  assign bus.imem_data  = mem[bus.imem_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_exec(input string tag, input logic [3:0] op, input logic cm);
    chk({tag, "_op"}, 32'(bus.opcode), 32'(op));
    chk({tag, "_commit"}, 32'(bus.commit), 32'(cm));
    chk({tag, "_rd_en"}, 32'(bus.imem_rd_en), 32'd0);
  endtask
  task automatic chk_fetch(input string tag, input logic [11:0] addr);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(addr));
    chk({tag, "_rd_en"}, 32'(bus.imem_rd_en), 32'd1);
    chk({tag, "_op"}, 32'(bus.opcode), 32'd0);
    chk({tag, "_commit"}, 32'(bus.commit), 32'd0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_op"}, 32'(bus.opcode), 32'd0);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_commit"}, 32'(bus.commit), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.imem_rd_en), 32'd0);
    chk({tag, "_dreq"}, 32'(bus.dmem_req), 32'd0);
    chk({tag, "_link"}, 32'(bus.link_pc), 32'd0);
    chk({tag, "_instr"}, 32'(bus.instr), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h1123;
    mem[1]     = 16'h3456;
    mem[2]     = 16'h6000;
    mem[3]     = 16'h1000;
    mem[4]     = 16'h70A5;
    mem[12'h0A5] = 16'hA010;
    mem[12'h010] = 16'hC123;
    mem[12'h011] = 16'hC123;
    mem[12'hFFF] = 16'h1000;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.dmem_ready = 1'b0;
    cyc();
    cyc();
    chk_reset("init");
    rst = 1'b0;
    bus.run = 1'b1;
    cyc();
    chk_fetch("f_add", 12'h000);
    chk("f_add_busy", 32'(bus.busy), 32'd1);
    cyc();
    chk_exec("add", 4'h1, 1'b1);
    chk("add_instr", 32'(bus.instr), 32'h1123);
    cyc();
    chk_fetch("f_mul", 12'h001);
    cyc();
    chk_exec("mul1", 4'h3, 1'b0);
    cyc();
    chk_exec("mul2", 4'h3, 1'b0);
    cyc();
    chk_exec("mul3", 4'h3, 1'b1);
    cyc();
    chk_fetch("f_div", 12'h002);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_exec($sformatf("div%0d", i), 4'h6, i == 7);
    end
    cyc();
    chk_fetch("f_nop", 12'h003);
    cyc();
    chk_exec("add2", 4'h1, 1'b1);
    cyc();
    chk_fetch("f_jal", 12'h004);
    cyc();
    chk_exec("jal", 4'h7, 1'b1);
    cyc();
    chk_fetch("f_j", 12'h0A5);
    chk("jal_link", 32'(bus.link_pc), 32'h005);
    cyc();
    chk_exec("j", 4'hA, 1'b1);
    cyc();
    chk_fetch("f_lw", 12'h010);
    chk("j_link", 32'(bus.link_pc), 32'h005);
    cyc();
    chk_exec("lw_w1", 4'hC, 1'b0);
    chk("lw_w1_dreq", 32'(bus.dmem_req), 32'd1);
    cyc();
    chk_exec("lw_w2", 4'hC, 1'b0);
    chk("lw_w2_dreq", 32'(bus.dmem_req), 32'd1);
    cyc();
    bus.dmem_ready = 1'b1;
    #1;
    chk_exec("lw_w3", 4'hC, 1'b1);
    chk("lw_w3_dreq", 32'(bus.dmem_req), 32'd1);
    cyc();
    bus.dmem_ready = 1'b0;
    #1;
    chk_fetch("f_lw2", 12'h011);
    chk("f_lw2_dreq", 32'(bus.dmem_req), 32'd0);
    cyc();
    chk_exec("lw2_w1", 4'hC, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    chk_exec("lw2_w2", 4'hC, 1'b0);
    mem[0] = 16'hAFFF;
    cyc();
    chk_reset("rst_exec");
    rst = 1'b0;
    cyc();
    chk_fetch("f_jfff", 12'h000);
    cyc();
    chk_exec("jfff", 4'hA, 1'b1);
    cyc();
    chk_fetch("f_fff", 12'hFFF);
    mem[0] = 16'h6000;
    cyc();
    chk_exec("add_fff", 4'h1, 1'b1);
    cyc();
    chk_fetch("f_wrap", 12'h000);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 2) bus.run = 1'b0;
      #1;
      chk_exec($sformatf("div_stop%0d", i), 4'h6, i == 7);
    end
    cyc();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_rd_en", 32'(bus.imem_rd_en), 32'd0);
    chk("idle_op", 32'(bus.opcode), 32'd0);
    chk("idle_addr", 32'(bus.imem_addr), 32'h001);
    cyc();
    cyc();
    chk("idle2_rd_en", 32'(bus.imem_rd_en), 32'd0);
    chk("idle2_commit", 32'(bus.commit), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
